// File: rtl/borrow_lookahead_subtractor_seq.sv
// Nibble-serial A - B - bin subtractor: 4-bit borrow lookahead per clock, borrow chained in a register.
// Optional zero/ovf result flags are enabled by defining SUB_FLAGS_EN.
module borrow_lookahead_subtractor_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SUB_FLAGS_EN
  output logic             zero,
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic             accept_s;
  logic             last_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             borrow_r;
  logic [IW-1:0]    index_r;
  logic [IW+1:0]    shamt_s;
  logic [WIDTH-1:0] a_sh_s;
  logic [WIDTH-1:0] b_sh_s;
  logic [4:0]       nib_s;
  logic [WIDTH-1:0] diff_next_s;

  // 4-bit borrow-lookahead subtract; returns {borrow_out, diff[3:0]}
  function automatic logic [4:0] nibble_sub(input logic [3:0] x, input logic [3:0] y, input logic c0);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = ~x & y;
    p    = ~(x ^ y);
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c[4], x ^ y ^ c[3:0]};
  endfunction

  // Current nibble datapath and the diff word with that nibble merged in
  always_comb begin
    shamt_s     = {index_r, 2'b00};
    last_s      = (index_r == LAST);
    a_sh_s      = a_r >> shamt_s;
    b_sh_s      = b_r >> shamt_s;
    nib_s       = nibble_sub(a_sh_s[3:0], b_sh_s[3:0], borrow_r);
    diff_next_s = (diff & ~(WIDTH'(4'hF) << shamt_s)) | (WIDTH'(nib_s[3:0]) << shamt_s);
  end

  // Next-state decode; start only counts while idle
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s  = RUN;
          accept_s = 1'b1;
        end else begin
          state_s  = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, operand latches, borrow chain and registered results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      ready    <= 1'b1;
      done     <= 1'b0;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
      index_r  <= {IW{1'b0}};
      diff     <= {WIDTH{1'b0}};
      bout     <= 1'b0;
`ifdef SUB_FLAGS_EN
      zero     <= 1'b0;
      ovf      <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      ready   <= (state_s == IDLE);
      done    <= (state_s == DONE);
      if (accept_s) begin
        a_r      <= a;
        b_r      <= b;
        borrow_r <= bin;
        index_r  <= {IW{1'b0}};
      end else if (state_r == RUN) begin
        diff     <= diff_next_s;
        borrow_r <= nib_s[4];
        index_r  <= index_r + IW'(1);
        if (last_s) begin
          bout <= nib_s[4];
`ifdef SUB_FLAGS_EN
          zero <= (diff_next_s == {WIDTH{1'b0}});
          ovf  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) & (diff_next_s[WIDTH-1] != a_r[WIDTH-1]);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_borrow_lookahead_subtractor_seq.sv
// Randomized self-checking bench for borrow_lookahead_subtractor_seq (WIDTH=16), with
// directed corner cases; flag checks follow SUB_FLAGS_EN.
module tb_borrow_lookahead_subtractor_seq;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         ready;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SUB_FLAGS_EN
  logic         zero;
  logic         ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  borrow_lookahead_subtractor_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .ready (ready),
    .done  (done),
    .diff  (diff),
`ifdef SUB_FLAGS_EN
    .zero  (zero),
    .ovf   (ovf),
`endif
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One operation; poke drives fresh operands with start high during RUN/DONE
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin, input bit poke);
    longint       full;
    logic [W-1:0] exp_diff;
    logic         exp_bout;
    int           k;
    bit           extra;
    full     = longint'(ta) - longint'(tb_) - longint'(tbin);
    exp_diff = W'(full);
    exp_bout = (full < 0);
    @(negedge clk);
    check_val("ready_before_start", {31'd0, ready}, 32'd1);
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (!done && k < 20) begin
      if (poke) begin
        start = 1'b1; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      end
      @(negedge clk);
      k++;
    end
    check_val("latency", k, N + 1);
    check_val("done_ready", {30'd0, done, ready}, 32'd2);
    check_val("diff", {16'd0, diff}, {16'd0, exp_diff});
    check_val("bout", {31'd0, bout}, {31'd0, exp_bout});
`ifdef SUB_FLAGS_EN
    check_val("zero", {31'd0, zero}, {31'd0, (exp_diff == 16'd0)});
    check_val("ovf", {31'd0, ovf},
              {31'd0, (ta[W-1] != tb_[W-1]) && (exp_diff[W-1] != ta[W-1])});
`endif
    @(negedge clk);
    start = 1'b0;
    check_val("idle_after_done", {30'd0, done, ready}, 32'd1);
    check_val("diff_held", {16'd0, diff}, {16'd0, exp_diff});
    if (poke) begin
      extra = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (done || !ready) extra = 1'b1;
      end
      check_val("no_second_done", {31'd0, extra}, 32'd0);
      check_val("diff_after_poke", {16'd0, diff}, {16'd0, exp_diff});
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #12;
    check_val("rst_outputs", {14'd0, ready, done, diff}, {14'd0, 1'b1, 1'b0, 16'd0});
    check_val("rst_bout", {31'd0, bout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(16'h1234, 16'h0234, 1'b0, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0, 1'b0);
    run_op(16'h00FF, 16'h000F, 1'b1, 1'b0);
    run_op(16'h0005, 16'h0005, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 1'b0);
    run_op(16'hA5C3, 16'h3C5A, 1'b1, 1'b1);

    // Abort mid-operation: outputs must clear immediately
    @(negedge clk);
    a = 16'h9ABC; b = 16'h1111; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("abort_outputs", {14'd0, ready, done, diff}, {14'd0, 1'b1, 1'b0, 16'd0});
    check_val("abort_bout", {31'd0, bout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(16'h9ABC, 16'h1111, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom);
      rb = ($urandom_range(3) == 0) ? ra : W'($urandom);
      run_op(ra, rb, 1'($urandom), (i % 8) == 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
